// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle sequencer and the datapath: instruction fields
// and status flags in, datapath/memory control strobes out.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_source;
  logic [1:0] result_src;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, func3, func7, alu_zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_control, imm_source, result_src,
           instr_done, illegal
  );

  modport slave (
    output op, func3, func7, alu_zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_control, imm_source, result_src,
           instr_done, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle RV32I core. Outputs are registered from the
// next state; only ir_write, pc_write and the store-completion pulse follow inputs.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    EXEC_R  = 4'd6,
    EXEC_I  = 4'd7,
    ALU_WB  = 4'd8,
    BEQ     = 4'd9,
    ILLEGAL = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_NONE = 3'b111;

  function automatic logic [2:0] alu_sel(input logic [2:0] f3, input logic sub_en);
    logic [2:0] sel;
    case (f3)
      3'b000:  sel = sub_en ? ALU_SUB : ALU_ADD;
      3'b010:  sel = ALU_SLT;
      3'b110:  sel = ALU_OR;
      3'b111:  sel = ALU_AND;
      default: sel = ALU_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic r_legal(input logic [6:0] f7, input logic [2:0] f3);
    logic ok;
    case ({f7, f3})
      {7'b0000000, 3'b000}, {7'b0100000, 3'b000}, {7'b0000000, 3'b010},
      {7'b0000000, 3'b110}, {7'b0000000, 3'b111}: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic i_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t     state_r, next_state_s;
  logic       store_r;
  logic       fetch_r, fetch_s;
  logic       beq_r, beq_s;
  logic       memwr_r, memwr_s;
  logic       done_r, done_s;
  logic       mem_req_r, mem_req_s;
  logic       mem_write_r, mem_write_s;
  logic       adr_src_r, adr_src_s;
  logic       reg_write_r, reg_write_s;
  logic [1:0] alu_src_a_r, alu_src_a_s;
  logic [1:0] alu_src_b_r, alu_src_b_s;
  logic [2:0] alu_control_r, alu_control_s;
  logic [1:0] imm_source_r, imm_source_s;
  logic [1:0] result_src_r, result_src_s;
  logic       illegal_r, illegal_s;

  // Next-state selection; fetch only advances once its request has been issued.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH:   next_state_s = (fetch_r && bus.mem_ready) ? DECODE : FETCH;
      DECODE: begin
        if (bus.op == OP_LW || bus.op == OP_SW) begin
          next_state_s = MEM_ADR;
        end else if (bus.op == OP_R) begin
          next_state_s = r_legal(bus.func7, bus.func3) ? EXEC_R : ILLEGAL;
        end else if (bus.op == OP_I) begin
          next_state_s = i_legal(bus.func3) ? EXEC_I : ILLEGAL;
        end else if (bus.op == OP_BR && bus.func3 == 3'b000) begin
          next_state_s = BEQ;
        end else begin
          next_state_s = ILLEGAL;
        end
      end
      MEM_ADR: next_state_s = store_r ? MEM_WR : MEM_RD;
      MEM_RD:  next_state_s = bus.mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:  next_state_s = bus.mem_ready ? FETCH : MEM_WR;
      EXEC_R:  next_state_s = ALU_WB;
      EXEC_I:  next_state_s = ALU_WB;
      MEM_WB:  next_state_s = FETCH;
      ALU_WB:  next_state_s = FETCH;
      BEQ:     next_state_s = FETCH;
      ILLEGAL: next_state_s = ILLEGAL;
      default: next_state_s = ILLEGAL;
    endcase
  end

  // Output values for the state being entered; MEM_ADR and EXEC are only entered from DECODE.
  always_comb begin
    fetch_s = 1'b0;  beq_s = 1'b0;  memwr_s = 1'b0;  done_s = 1'b0;
    mem_req_s = 1'b0;  mem_write_s = 1'b0;  adr_src_s = 1'b0;  reg_write_s = 1'b0;
    alu_src_a_s = 2'b00;  alu_src_b_s = 2'b00;  alu_control_s = ALU_NONE;
    imm_source_s = 2'b00;  result_src_s = 2'b00;  illegal_s = 1'b0;
    case (next_state_s)
      FETCH: begin
        fetch_s = 1'b1;  mem_req_s = 1'b1;  alu_src_b_s = 2'b10;
        alu_control_s = ALU_ADD;  result_src_s = 2'b10;
      end
      DECODE: begin
        alu_src_a_s = 2'b01;  alu_src_b_s = 2'b01;  imm_source_s = 2'b10;
        alu_control_s = ALU_ADD;
      end
      MEM_ADR: begin
        alu_src_a_s = 2'b10;  alu_src_b_s = 2'b01;  alu_control_s = ALU_ADD;
        imm_source_s = (bus.op == OP_SW) ? 2'b01 : 2'b00;
      end
      MEM_RD: begin
        mem_req_s = 1'b1;  adr_src_s = 1'b1;
      end
      MEM_WB: begin
        result_src_s = 2'b01;  reg_write_s = 1'b1;  done_s = 1'b1;
      end
      MEM_WR: begin
        memwr_s = 1'b1;  mem_req_s = 1'b1;  mem_write_s = 1'b1;  adr_src_s = 1'b1;
      end
      EXEC_R: begin
        alu_src_a_s = 2'b10;  alu_src_b_s = 2'b00;
        alu_control_s = alu_sel(bus.func3, bus.func7 == 7'b0100000);
      end
      EXEC_I: begin
        alu_src_a_s = 2'b10;  alu_src_b_s = 2'b01;  imm_source_s = 2'b00;
        alu_control_s = alu_sel(bus.func3, 1'b0);
      end
      ALU_WB: begin
        result_src_s = 2'b00;  reg_write_s = 1'b1;  done_s = 1'b1;
      end
      BEQ: begin
        beq_s = 1'b1;  alu_src_a_s = 2'b10;  alu_src_b_s = 2'b00;
        alu_control_s = ALU_SUB;  result_src_s = 2'b00;  done_s = 1'b1;
      end
      ILLEGAL: illegal_s = 1'b1;
      default: illegal_s = 1'b1;
    endcase
  end

  // State, latched load/store flavour and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;  store_r <= 1'b0;
      fetch_r <= 1'b0;  beq_r <= 1'b0;  memwr_r <= 1'b0;  done_r <= 1'b0;
      mem_req_r <= 1'b0;  mem_write_r <= 1'b0;  adr_src_r <= 1'b0;  reg_write_r <= 1'b0;
      alu_src_a_r <= 2'b00;  alu_src_b_r <= 2'b00;  alu_control_r <= ALU_NONE;
      imm_source_r <= 2'b00;  result_src_r <= 2'b00;  illegal_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      store_r <= (state_r == DECODE) ? (bus.op == OP_SW) : store_r;
      fetch_r <= fetch_s;  beq_r <= beq_s;  memwr_r <= memwr_s;  done_r <= done_s;
      mem_req_r <= mem_req_s;  mem_write_r <= mem_write_s;
      adr_src_r <= adr_src_s;  reg_write_r <= reg_write_s;
      alu_src_a_r <= alu_src_a_s;  alu_src_b_r <= alu_src_b_s;
      alu_control_r <= alu_control_s;  imm_source_r <= imm_source_s;
      result_src_r <= result_src_s;  illegal_r <= illegal_s;
    end
  end

  assign bus.mem_req     = mem_req_r;
  assign bus.mem_write   = mem_write_r;
  assign bus.adr_src     = adr_src_r;
  assign bus.reg_write   = reg_write_r;
  assign bus.alu_src_a   = alu_src_a_r;
  assign bus.alu_src_b   = alu_src_b_r;
  assign bus.alu_control = alu_control_r;
  assign bus.imm_source  = imm_source_r;
  assign bus.result_src  = result_src_r;
  assign bus.illegal     = illegal_r;
  // Handshake-completion strobes; all source flags are cleared by reset.
  assign bus.ir_write    = fetch_r & bus.mem_ready;
  assign bus.pc_write    = (fetch_r & bus.mem_ready) | (beq_r & bus.alu_zero);
  assign bus.instr_done  = done_r | (memwr_r & bus.mem_ready);
endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: every instruction is expanded into a
// per-cycle list of inputs and expected outputs, then replayed and compared.
module tb_multicycle_control;
  logic clk;
  logic rst_n;
  multicycle_control_if bus ();

  multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_ILL = 5;

  typedef struct {
    logic       mr, az;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       mem_req, mem_write, adr, ir, pc, rw;
    logic [1:0] a, b;
    logic [2:0] alu;
    logic [1:0] imm, res;
    logic       done, ill;
    string      tag;
  } cyc_t;

  cyc_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t base(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input string tag);
    cyc_t c;
    c.mr = 1'($urandom);  c.az = 1'($urandom);
    c.op = op;  c.f3 = f3;  c.f7 = f7;
    c.mem_req = 1'b0;  c.mem_write = 1'b0;  c.adr = 1'b0;  c.ir = 1'b0;  c.pc = 1'b0;
    c.rw = 1'b0;  c.a = 2'b00;  c.b = 2'b00;  c.alu = 3'b111;  c.imm = 2'b00;
    c.res = 2'b00;  c.done = 1'b0;  c.ill = 1'b0;  c.tag = tag;
    return c;
  endfunction

  function automatic logic [18:0] pack(input cyc_t c);
    return {c.mem_req, c.mem_write, c.adr, c.ir, c.pc, c.rw, c.a, c.b, c.alu,
            c.imm, c.res, c.done, c.ill};
  endfunction

  function automatic logic [18:0] pack_act();
    return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
            bus.imm_source, bus.result_src, bus.instr_done, bus.illegal};
  endfunction

  // Instruction class and ALU operation straight from the supported-instruction table.
  function automatic void classify(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, output int kind,
                                   output logic [2:0] alu);
    kind = K_ILL;
    alu  = 3'b111;
    if (op == 7'b0000011) kind = K_LW;
    else if (op == 7'b0100011) kind = K_SW;
    else if (op == 7'b0110011) begin
      case ({f7, f3})
        10'b0000000_000: begin kind = K_R; alu = 3'b000; end
        10'b0100000_000: begin kind = K_R; alu = 3'b001; end
        10'b0000000_010: begin kind = K_R; alu = 3'b101; end
        10'b0000000_110: begin kind = K_R; alu = 3'b011; end
        10'b0000000_111: begin kind = K_R; alu = 3'b010; end
        default: kind = K_ILL;
      endcase
    end else if (op == 7'b0010011) begin
      case (f3)
        3'b000: begin kind = K_I; alu = 3'b000; end
        3'b010: begin kind = K_I; alu = 3'b101; end
        3'b110: begin kind = K_I; alu = 3'b011; end
        3'b111: begin kind = K_I; alu = 3'b010; end
        default: kind = K_ILL;
      endcase
    end else if (op == 7'b1100011 && f3 == 3'b000) begin
      kind = K_BEQ;  alu = 3'b001;
    end else kind = K_ILL;
  endfunction

  // Expand one instruction into its cycle-by-cycle expectations.
  task automatic gen(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input int wf, input int wm, input logic az);
    cyc_t c;
    int kind;
    logic [2:0] alu;
    classify(op, f3, f7, kind, alu);
    for (int i = 0; i <= wf; i++) begin
      c = base(7'($urandom), 3'($urandom), 7'($urandom), "fetch");
      c.mr = (i == wf);  c.mem_req = 1'b1;  c.b = 2'b10;  c.alu = 3'b000;
      c.res = 2'b10;  c.ir = c.mr;  c.pc = c.mr;
      q.push_back(c);
    end
    c = base(op, f3, f7, "decode");
    c.a = 2'b01;  c.b = 2'b01;  c.imm = 2'b10;  c.alu = 3'b000;
    q.push_back(c);
    if (kind == K_LW || kind == K_SW) begin
      c = base(op, f3, f7, "mem_adr");
      c.a = 2'b10;  c.b = 2'b01;  c.alu = 3'b000;  c.imm = (kind == K_SW) ? 2'b01 : 2'b00;
      q.push_back(c);
      for (int i = 0; i <= wm; i++) begin
        c = base(op, f3, f7, (kind == K_SW) ? "mem_wr" : "mem_rd");
        c.mr = (i == wm);  c.mem_req = 1'b1;  c.adr = 1'b1;
        c.mem_write = (kind == K_SW);
        c.done = (kind == K_SW) && c.mr;
        q.push_back(c);
      end
      if (kind == K_LW) begin
        c = base(op, f3, f7, "mem_wb");
        c.res = 2'b01;  c.rw = 1'b1;  c.done = 1'b1;
        q.push_back(c);
      end
    end else if (kind == K_R || kind == K_I) begin
      c = base(op, f3, f7, "exec");
      c.a = 2'b10;  c.b = (kind == K_I) ? 2'b01 : 2'b00;  c.alu = alu;
      q.push_back(c);
      c = base(op, f3, f7, "alu_wb");
      c.rw = 1'b1;  c.done = 1'b1;
      q.push_back(c);
    end else if (kind == K_BEQ) begin
      c = base(op, f3, f7, "beq");
      c.az = az;  c.a = 2'b10;  c.alu = 3'b001;  c.pc = az;  c.done = 1'b1;
      q.push_back(c);
    end else begin
      for (int i = 0; i < 10; i++) begin
        c = base(op, f3, f7, "illegal");
        c.ill = 1'b1;
        q.push_back(c);
      end
    end
  endtask

  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      @(posedge clk);
      #2;
      bus.mem_ready = c.mr;  bus.alu_zero = c.az;
      bus.op = c.op;  bus.func3 = c.f3;  bus.func7 = c.f7;
      #2;
      check(c.tag, 32'(pack_act()), 32'(pack(c)));
    end
  endtask

  task automatic run_all();
    run_n(q.size());
  endtask

  // Assert reset mid-cycle, check defaults asynchronously and per cycle, release.
  task automatic do_reset(input int cycles);
    logic [18:0] dflt;
    dflt = pack(base(7'd0, 3'd0, 7'd0, "rst"));
    q.delete();
    @(posedge clk);
    #2;
    bus.mem_ready = 1'b1;  bus.alu_zero = 1'b1;  rst_n = 1'b0;
    #1;
    check("reset_async", 32'(pack_act()), 32'(dflt));
    repeat (cycles) begin
      @(posedge clk);
      #4;
      check("reset_hold", 32'(pack_act()), 32'(dflt));
    end
    rst_n = 1'b1;
  endtask

  logic [9:0] r_tab [5];
  logic [2:0] i_tab [4];

  initial begin
    int kind;
    logic [2:0] alu;
    logic [6:0] op, f7;
    logic [2:0] f3;
    int r, wf, wm;
    r_tab = '{10'b0000000_000, 10'b0100000_000, 10'b0000000_010,
              10'b0000000_110, 10'b0000000_111};
    i_tab = '{3'b000, 3'b010, 3'b110, 3'b111};
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;  bus.alu_zero = 1'b0;
    bus.op = 7'd0;  bus.func3 = 3'd0;  bus.func7 = 7'd0;
    do_reset(3);

    // Directed cases, with literal cycle counts and ALU codes pinning the model.
    gen(7'b0000011, 3'b010, 7'd0, 0, 0, 1'b0);
    check("lw_cycles", 32'(q.size()), 32'd5);
    run_all();
    gen(7'b0100011, 3'b010, 7'd0, 0, 2, 1'b0);
    check("sw_wait2_cycles", 32'(q.size()), 32'd6);
    run_all();
    gen(7'b0100011, 3'b010, 7'd0, 0, 0, 1'b0);
    check("sw_cycles", 32'(q.size()), 32'd4);
    run_all();
    classify(7'b0110011, 3'b000, 7'b0100000, kind, alu);
    check("sub_alu", 32'(alu), 32'h1);
    gen(7'b0110011, 3'b000, 7'b0100000, 0, 0, 1'b0);
    check("r_cycles", 32'(q.size()), 32'd4);
    run_all();
    classify(7'b0110011, 3'b010, 7'b0000000, kind, alu);
    check("slt_alu", 32'(alu), 32'h5);
    gen(7'b0110011, 3'b010, 7'b0000000, 1, 0, 1'b0);
    run_all();
    classify(7'b0010011, 3'b000, 7'b0100000, kind, alu);
    check("addi_alu", 32'(alu), 32'h0);
    gen(7'b0010011, 3'b000, 7'b0100000, 0, 0, 1'b0);
    check("i_cycles", 32'(q.size()), 32'd4);
    run_all();
    gen(7'b1100011, 3'b000, 7'd0, 0, 0, 1'b1);
    check("beq_cycles", 32'(q.size()), 32'd3);
    run_all();
    gen(7'b1100011, 3'b000, 7'd0, 0, 0, 1'b0);
    run_all();
    gen(7'b1101111, 3'b000, 7'd0, 0, 0, 1'b0);
    run_all();
    do_reset(2);
    gen(7'b0110011, 3'b001, 7'd0, 0, 0, 1'b0);
    run_all();
    do_reset(1);
    gen(7'b0000011, 3'b010, 7'd0, 0, 2, 1'b0);
    run_n(4);
    do_reset(2);

    // Randomised instruction stream with random wait states.
    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 19);
      op = 7'($urandom);  f3 = 3'($urandom);  f7 = 7'($urandom);
      if (r < 4) op = 7'b0000011;
      else if (r < 8) op = 7'b0100011;
      else if (r < 12) begin
        op = 7'b0110011;
        {f7, f3} = r_tab[$urandom_range(0, 4)];
      end else if (r < 16) begin
        op = 7'b0010011;
        f3 = i_tab[$urandom_range(0, 3)];
      end else if (r < 19) begin
        op = 7'b1100011;  f3 = 3'b000;
      end else begin
        case ($urandom_range(0, 4))
          0: op = 7'b1101111;
          1: begin op = 7'b0110011; f3 = 3'b001; f7 = 7'd0; end
          2: begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000001; end
          3: begin op = 7'b0010011; f3 = 3'b001; end
          default: begin op = 7'b1100011; f3 = 3'b001; end
        endcase
      end
      wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      wm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      gen(op, f3, f7, wf, wm, 1'($urandom));
      run_all();
      classify(op, f3, f7, kind, alu);
      if (kind == K_ILL) do_reset(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
